// File: rtl/tx_pkg.sv
// Shared constants for the PAM4 channel transmitter: PAM4 levels, Gray map,
// FSM states and LFSR polynomial taps.
package tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN
    } tx_state_e;

    localparam logic signed [2:0] LVL_M3 = -3'sd3;
    localparam logic signed [2:0] LVL_M1 = -3'sd1;
    localparam logic signed [2:0] LVL_P1 = 3'sd1;
    localparam logic signed [2:0] LVL_P3 = 3'sd3;

    // Feedback = s[TAP_A] ^ s[TAP_B], output taken from the MSB.
    localparam int PRBS15_W     = 15;
    localparam int PRBS15_TAP_A = 14;
    localparam int PRBS15_TAP_B = 13;

    localparam int                PRBS23_W     = 23;
    localparam int                PRBS23_TAP_A = 22;
    localparam int                PRBS23_TAP_B = 17;
    localparam logic [22:0]       PRBS23_SEED  = 23'h1;

    // One level unit is worth 0.25, i.e. two extra fractional bits.
    localparam int SYM_SCALE_SHIFT = 2;

    function automatic logic signed [2:0] gray_map(input logic [1:0] b);
        logic signed [2:0] lvl;
        case (b)
            2'b00:   lvl = LVL_M3;
            2'b01:   lvl = LVL_M1;
            2'b11:   lvl = LVL_P1;
            default: lvl = LVL_P3;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/prbs_gen.sv
// Fibonacci LFSR that shifts twice per advance and presents the next two
// output bits MSB-first. TX_NOISE_EN adds a port exposing the 4 state LSBs.
module prbs_gen #(
    parameter int               WIDTH = 15,
    parameter int               TAP_A = 14,
    parameter int               TAP_B = 13,
    parameter logic [WIDTH-1:0] SEED  = '1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       adv,
    output logic [1:0] bits
`ifdef TX_NOISE_EN
    ,
    output logic [3:0] lsbs
`endif
);

    logic [WIDTH-1:0] state_reg;
    logic [WIDTH-1:0] once;
    logic [WIDTH-1:0] state_next;

    always_comb begin
        once       = {state_reg[WIDTH-2:0], state_reg[TAP_A] ^ state_reg[TAP_B]};
        state_next = {once[WIDTH-2:0], once[TAP_A] ^ once[TAP_B]};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= SEED;
        end else if (adv) begin
            state_reg <= state_next;
        end
    end

    // The MSB now is the first bit out; the bit below it is the second.
    assign bits = state_reg[WIDTH-1:WIDTH-2];

`ifdef TX_NOISE_EN
    assign lsbs = state_reg[3:0];
`endif

endmodule

// File: rtl/pam4_channel_tx.sv
// PRBS15 -> Gray PAM4 -> programmable ISI FIR -> saturated Q(NB_OUT,NBF_OUT)
// samples behind valid/ready. Define TX_NOISE_EN to add PRBS23 noise.
module pam4_channel_tx
    import tx_pkg::*;
#(
    parameter int          NB_OUT    = 18,
    parameter int          NBF_OUT   = 15,
    parameter int          CH_LEN    = 5,
    parameter int          NB_CH     = 8,
    parameter int          NBF_CH    = 7,
    parameter logic [14:0] PRBS_SEED = 15'h7FFF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_en,
    input  logic                     i_ready,
    input  logic                     i_coeff_we,
    input  logic [3:0]               i_coeff_addr,
    input  logic signed [NB_CH-1:0]  i_coeff_data,
    output logic signed [NB_OUT-1:0] o_sample,
    output logic signed [2:0]        o_symbol,
    output logic                     o_valid
);

    localparam int PROD_W      = 3 + NB_CH;
    localparam int ACC_W       = PROD_W + $clog2(CH_LEN);
    localparam int ALIGN_SHIFT = NBF_OUT - NBF_CH - SYM_SCALE_SHIFT;
    localparam int SUM_W       = ACC_W + ALIGN_SHIFT + 1;
    localparam int WIDE_W      = (SUM_W > NB_OUT) ? SUM_W + 1 : NB_OUT + 2;

    localparam logic signed [WIDE_W-1:0] SAT_MAX  = WIDE_W'((64'sd1 <<< (NB_OUT - 1)) - 64'sd1);
    localparam logic signed [WIDE_W-1:0] SAT_MIN  = -SAT_MAX;
    localparam logic signed [NB_CH-1:0]  H0_RESET = NB_CH'((1 << (NB_CH - 1)) - 1);

    tx_state_e state_reg, state_next;
    logic [4:0] cnt_reg, cnt_next;
    logic       valid_reg, valid_next;
    logic       adv;
    logic       clear;

    logic [1:0]               prbs_bits;
    logic signed [2:0]        level;
    logic signed [2:0]        hist_reg [CH_LEN-1];
    logic signed [2:0]        dly_next [CH_LEN];
    logic signed [NB_CH-1:0]  taps_reg [CH_LEN];
    logic signed [PROD_W-1:0] prod     [CH_LEN];
    logic signed [ACC_W-1:0]  acc;
    logic signed [WIDE_W-1:0] wide;
    logic signed [NB_OUT-1:0] sat;
    logic signed [NB_OUT-1:0] sample_reg;
    logic signed [2:0]        symbol_reg;

    prbs_gen #(
        .WIDTH(PRBS15_W),
        .TAP_A(PRBS15_TAP_A),
        .TAP_B(PRBS15_TAP_B),
        .SEED (PRBS_SEED)
    ) u_prbs15 (
        .clk (clk),
        .rst (rst),
        .adv (adv),
`ifdef TX_NOISE_EN
        .lsbs(),
`endif
        .bits(prbs_bits)
    );

`ifdef TX_NOISE_EN
    logic [3:0] noise_lsbs;
    logic [1:0] noise_bits;

    prbs_gen #(
        .WIDTH(PRBS23_W),
        .TAP_A(PRBS23_TAP_A),
        .TAP_B(PRBS23_TAP_B),
        .SEED (PRBS23_SEED)
    ) u_noise (
        .clk (clk),
        .rst (rst),
        .adv (adv),
        .lsbs(noise_lsbs),
        .bits(noise_bits)
    );
`endif

    assign level = gray_map(prbs_bits);

    // dly_next is the delay line as it will be after this advance; the FIR
    // runs on it so the sample leaves on the same edge as its symbol.
    generate
        for (genvar gi = 0; gi < CH_LEN; gi++) begin : g_tap
            if (gi == 0) begin : g_head
                assign dly_next[gi] = level;
            end else begin : g_tail
                assign dly_next[gi] = hist_reg[gi-1];
            end
            assign prod[gi] = PROD_W'(dly_next[gi]) * PROD_W'(taps_reg[gi]);
        end
    endgenerate

    always_comb begin
        acc = '0;
        for (int k = 0; k < CH_LEN; k++) begin
            acc = acc + ACC_W'(prod[k]);
        end
`ifdef TX_NOISE_EN
        wide = (WIDE_W'(acc) <<< ALIGN_SHIFT) + WIDE_W'($signed(noise_lsbs));
`else
        wide = WIDE_W'(acc) <<< ALIGN_SHIFT;
`endif
        if (wide > SAT_MAX) begin
            sat = SAT_MAX[NB_OUT-1:0];
        end else if (wide < SAT_MIN) begin
            sat = SAT_MIN[NB_OUT-1:0];
        end else begin
            sat = wide[NB_OUT-1:0];
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        valid_next = valid_reg;
        clear      = 1'b0;
        adv        = (state_reg != ST_IDLE || i_en) && (!valid_reg || i_ready);
        if (!i_en) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
            valid_next = 1'b0;
            clear      = 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next = ST_FILL;
                    cnt_next   = 5'd1;
                end
                ST_FILL: begin
                    if (adv) begin
                        cnt_next = cnt_reg + 5'd1;
                        if (cnt_reg == 5'(CH_LEN - 1)) begin
                            state_next = ST_RUN;
                            valid_next = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            valid_reg <= valid_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < CH_LEN; k++) begin
                taps_reg[k] <= (k == 0) ? H0_RESET : '0;
            end
            for (int k = 0; k < CH_LEN - 1; k++) begin
                hist_reg[k] <= '0;
            end
            sample_reg <= '0;
            symbol_reg <= '0;
        end else begin
            for (int k = 0; k < CH_LEN; k++) begin
                if (i_coeff_we && i_coeff_addr == 4'(k)) begin
                    taps_reg[k] <= i_coeff_data;
                end
            end
            for (int k = 0; k < CH_LEN - 1; k++) begin
                if (clear) begin
                    hist_reg[k] <= '0;
                end else if (adv) begin
                    hist_reg[k] <= dly_next[k];
                end
            end
            // An advance on the enable-drop edge only consumes PRBS bits.
            if (adv && i_en) begin
                sample_reg <= sat;
                symbol_reg <= level;
            end
        end
    end

    assign o_sample = sample_reg;
    assign o_symbol = symbol_reg;
    assign o_valid  = valid_reg;

endmodule

// File: tb/tb_pam4_channel_tx.sv
// Self-checking bench for pam4_channel_tx: directed steps plus random
// backpressure and tap writes, checked against a bit-level behavioural model.
module tb_pam4_channel_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              en, ready, we;
    logic [3:0]        addr;
    logic signed [7:0] data;
    logic signed [17:0] sample;
    logic signed [2:0]  symbol;
    logic               valid;

    logic              en_s, ready_s, we_s;
    logic [3:0]        addr_s;
    logic signed [7:0] data_s;
    logic signed [17:0] sample_s;
    logic signed [2:0]  symbol_s;
    logic               valid_s;

    pam4_channel_tx dut (
        .clk         (clk),
        .rst         (rst),
        .i_en        (en),
        .i_ready     (ready),
        .i_coeff_we  (we),
        .i_coeff_addr(addr),
        .i_coeff_data(data),
        .o_sample    (sample),
        .o_symbol    (symbol),
        .o_valid     (valid)
    );

    pam4_channel_tx #(
        .CH_LEN   (8),
        .PRBS_SEED(15'h5555)
    ) dut_sat (
        .clk         (clk),
        .rst         (rst),
        .i_en        (en_s),
        .i_ready     (ready_s),
        .i_coeff_we  (we_s),
        .i_coeff_addr(addr_s),
        .i_coeff_data(data_s),
        .o_sample    (sample_s),
        .o_symbol    (symbol_s),
        .o_valid     (valid_s)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model, one slot per instance (0 = default, 1 = saturation).
    int CHLEN [2] = '{5, 8};
    int SEEDS [2] = '{32'h7FFF, 32'h5555};
    int GRAY  [4] = '{-3, -1, 3, 1};
    int m_lfsr   [2];
    int m_hist   [2][16];
    int m_taps   [2][16];
    bit m_active [2];
    int m_nadv   [2];
    bit m_valid  [2];
    int m_sym    [2];
    int m_sample [2];

    task automatic m_reset(input int m);
        m_lfsr[m] = SEEDS[m];
        for (int k = 0; k < 16; k++) begin
            m_hist[m][k] = 0;
            m_taps[m][k] = 0;
        end
        m_taps[m][0] = 127;
        m_active[m]  = 1'b0;
        m_nadv[m]    = 0;
        m_valid[m]   = 1'b0;
        m_sym[m]     = 0;
        m_sample[m]  = 0;
    endtask

    task automatic m_bit(input int m, output int b);
        int fb;
        b  = (m_lfsr[m] >> 14) & 1;
        fb = ((m_lfsr[m] >> 14) ^ (m_lfsr[m] >> 13)) & 1;
        m_lfsr[m] = ((m_lfsr[m] << 1) | fb) & 32'h7FFF;
    endtask

    task automatic m_update(input int m, input bit r, input bit e, input bit rdy,
                            input bit w, input logic [3:0] a, input logic signed [7:0] d);
        bit go;
        int b1, b0, lvl, acc;
        if (!r) begin
            m_reset(m);
            return;
        end
        lvl = 0;
        go  = (m_active[m] || e) && (!m_valid[m] || rdy);
        if (go) begin
            m_bit(m, b1);
            m_bit(m, b0);
            lvl = GRAY[b1 * 2 + b0];
        end
        if (!e) begin
            m_active[m] = 1'b0;
            m_valid[m]  = 1'b0;
            m_nadv[m]   = 0;
            for (int k = 0; k < 16; k++) m_hist[m][k] = 0;
        end else if (go) begin
            for (int k = 15; k > 0; k--) m_hist[m][k] = m_hist[m][k-1];
            m_hist[m][0] = lvl;
            acc = 0;
            for (int k = 0; k < CHLEN[m]; k++) acc += m_hist[m][k] * m_taps[m][k];
            acc = acc * 64;
            if (acc > 131071) acc = 131071;
            if (acc < -131071) acc = -131071;
            m_sample[m] = acc;
            m_sym[m]    = lvl;
            m_active[m] = 1'b1;
            m_nadv[m]++;
            if (m_nadv[m] >= CHLEN[m]) m_valid[m] = 1'b1;
        end
        if (w && int'(a) < CHLEN[m]) m_taps[m][a] = d;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic logic [31:0] sx18(input logic [17:0] v);
        return {{14{v[17]}}, v};
    endfunction

    function automatic logic [31:0] sx3(input logic [2:0] v);
        return {{29{v[2]}}, v};
    endfunction

    task automatic tick();
        m_update(0, rst, en, ready, we, addr, data);
        m_update(1, rst, en_s, ready_s, we_s, addr_s, data_s);
        @(posedge clk);
        #1;
        chk("dflt_valid",  {31'b0, valid},    32'(m_valid[0]));
        chk("dflt_symbol", sx3(symbol),       32'(m_sym[0]));
        chk("dflt_sample", sx18(sample),      32'(m_sample[0]));
        chk("sat_valid",   {31'b0, valid_s},  32'(m_valid[1]));
        chk("sat_symbol",  sx3(symbol_s),     32'(m_sym[1]));
        chk("sat_sample",  sx18(sample_s),    32'(m_sample[1]));
        if (valid)   $display("t=%0t dflt sym=%0d sample=%0d", $time, symbol, sample);
        if (valid_s) $display("t=%0t sat  sym=%0d sample=%0d", $time, symbol_s, sample_s);
    endtask

    task automatic default_run();
        en    = 1'b1;
        ready = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            chk("run_valid_edge", {31'b0, valid}, 32'(t >= 5));
            if (t <= 7) begin
                chk("run_first_symbol", sx3(symbol), 32'd1);
                chk("run_first_sample", sx18(sample), 32'd8128);
            end
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; ready = 1'b1; we = 1'b0; addr = '0; data = '0;
        en_s = 1'b0; ready_s = 1'b1; we_s = 1'b0; addr_s = '0; data_s = '0;

        repeat (3) begin
            tick();
            chk("reset_valid", {31'b0, valid}, 32'd0);
            chk("reset_sample", sx18(sample), 32'd0);
        end
        rst = 1'b1;
        repeat (10) begin
            tick();
            chk("idle_valid", {31'b0, valid}, 32'd0);
            chk("idle_symbol", sx3(symbol), 32'd0);
        end

        default_run();

        // Mid-run reset, then the default sequence must repeat exactly.
        rst = 1'b0;
        en  = 1'b0;
        tick();
        chk("midrst_valid", {31'b0, valid}, 32'd0);
        chk("midrst_sample", sx18(sample), 32'd0);
        chk("midrst_symbol", sx3(symbol), 32'd0);
        rst = 1'b1;
        default_run();

        // Two-tap channel h0=64, h1=32 from a fresh seed.
        rst = 1'b0;
        en  = 1'b0;
        tick();
        rst = 1'b1;
        we = 1'b1; addr = 4'd0; data = 8'sd64;
        tick();
        addr = 4'd1; data = 8'sd32;
        tick();
        we = 1'b0;
        en = 1'b1;
        for (int t = 1; t <= 7; t++) begin
            tick();
            if (t >= 5) chk("two_tap_sample", sx18(sample), 32'd6144);
        end

        // Random backpressure and random tap writes (including ignored indices).
        for (int i = 0; i < 200; i++) begin
            ready = ($urandom_range(0, 3) != 0);
            we    = ($urandom_range(0, 9) == 0);
            addr  = 4'($urandom_range(0, 15));
            data  = 8'($urandom);
            tick();
        end
        we = 1'b0;

        // Explicit three-cycle stall in RUN.
        ready = 1'b1;
        repeat (2) tick();
        ready = 1'b0;
        repeat (3) tick();
        ready = 1'b1;
        repeat (10) tick();

        // Enable drop while flowing, then FILL must repeat.
        en = 1'b0;
        tick();
        chk("endrop_valid", {31'b0, valid}, 32'd0);
        en = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            tick();
            chk("refill_valid", {31'b0, valid}, 32'(t >= 5));
        end

        // Enable drop during a stall discards the pending sample.
        ready = 1'b0;
        tick();
        en = 1'b0;
        tick();
        chk("stall_endrop_valid", {31'b0, valid}, 32'd0);
        en    = 1'b1;
        ready = 1'b1;
        repeat (8) tick();
        en = 1'b0;
        tick();

        // Saturation: 8 taps at 127, seed 0x5555.
        we_s = 1'b1;
        for (int a = 0; a < 8; a++) begin
            addr_s = 4'(a);
            data_s = 8'sd127;
            tick();
        end
        we_s    = 1'b0;
        en_s    = 1'b1;
        ready_s = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            chk("sat_valid_edge", {31'b0, valid_s}, 32'(t >= 8));
            if (t <= 7) chk("sat_plus3_symbol", sx3(symbol_s), 32'd3);
            if (t == 8) begin
                chk("sat_first_run_sample", sx18(sample_s), 32'd131071);
                chk("sat_first_run_symbol", sx3(symbol_s), 32'd1);
            end
        end
        for (int i = 0; i < 40; i++) begin
            ready_s = ($urandom_range(0, 2) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pam4_channel_tx.md
# pam4_channel_tx

- Transmit-side stimulus source for the equalizer/CMA receive chain.
- Generates PRBS15 data, Gray-maps it to PAM4, and passes the symbols through a programmable ISI channel FIR.
- Emits saturated fixed-point samples in the same Q(NB_OUT,NBF_OUT) format the receive FIR consumes, behind a valid/ready handshake.
- Replaces file-driven channel symbols in on-chip and loop-back tests.

## Interface
Parameters:
- NB_OUT, 18, output sample width (signed)
- NBF_OUT, 15, output fractional bits
- CH_LEN, 5, channel FIR taps (2..16)
- NB_CH, 8, channel coefficient width (signed)
- NBF_CH, 7, channel coefficient fractional bits
- PRBS_SEED, 15'h7FFF, PRBS15 reset state (nonzero)

Ports (reset rst, synchronous, active-low; clock clk):
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- i_en  in  1  run enable
- i_ready  in  1  downstream accepts o_sample
- i_coeff_we  in  1  channel tap write strobe
- i_coeff_addr  in  4  tap index (0 = cursor); index ≥ CH_LEN ignored
- i_coeff_data  in  NB_CH  tap value, Q(NB_CH,NBF_CH)
- o_sample  out  NB_OUT  channel output sample
- o_symbol  out  3  signed PAM4 level code of newest symbol {-3,-1,+1,+3}
- o_valid  out  1  o_sample/o_symbol valid

## Operation
- FSM states: IDLE, FILL, RUN.
  - IDLE→FILL on i_en=1.
  - FILL→RUN after CH_LEN-1 advances.
  - Any state→IDLE on i_en=0.
- Entering IDLE clears the delay line and o_valid. PRBS state is kept.
- Advance condition: state≠IDLE (or IDLE with i_en=1) and (!o_valid or i_ready).
- On each advance:
  - PRBS15 (x^15+x^14+1) shifts twice. Output bit = s[14] before the shift; feedback = s[14]^s[13].
  - First bit is the MSB.
- Gray map: 00→-3, 01→-1, 11→+1, 10→+3.
- The new level L is shifted into delay line d[0]; older symbols move to d[1..CH_LEN-1].
- FIR: acc = Σ L_k·h_k.
  - Products are 3+NB_CH bits.
  - acc width is 3+NB_CH+clog2(CH_LEN), fraction NBF_CH.
- Symbol scale is 0.25 per level unit, so acc fraction = NBF_CH+2.
- Align to NBF_OUT by shifting left by NBF_OUT-NBF_CH-2 (6 at defaults).
- Saturate to ±(2^(NB_OUT-1)-1); no wrap. The most negative code is clamped to -(2^(NB_OUT-1)-1).
- Coefficient writes take effect on the next advance and are allowed in any state, including during a stall.
- Reset tap values: h0=127, all other taps 0.

## Timing
- Reset values:
  - o_sample=0, o_symbol=0, o_valid=0
  - state=IDLE, delay line 0, PRBS=PRBS_SEED, taps at reset values
- IDLE with i_en=1: the same edge performs advance #1 and enters FILL.
- FILL: o_valid stays 0.
- o_valid rises on the CH_LEN-th advance edge.
- Advance latency: o_sample and o_symbol are registered on the same edge as the advance, which is 1 cycle after the inputs to that advance.
- Stall (o_valid=1, i_ready=0): PRBS, delay line, o_sample, o_symbol and o_valid all hold. No symbol is dropped or duplicated.
- i_en falling while o_valid=1 and i_ready=0: the pending sample is discarded and o_valid=0 next cycle.
- rst=0 mid-operation: all reset values apply on the next edge; the PRBS is reseeded.

## Configuration
- TX_NOISE_EN defined:
  - A second LFSR (PRBS23, x^23+x^18+1, seed 23'h1) adds its 4 LSBs as signed noise (-8..+7 LSB of o_sample) before saturation.
  - The noise LFSR advances only on advance.
- TX_NOISE_EN undefined: no noise LFSR is instantiated and output is fully deterministic.
- All directed test values below assume TX_NOISE_EN undefined.

## Structure
- Package tx_pkg holds:
  - PAM4 level constants and the Gray-map function
  - FSM state enum
  - PRBS15/PRBS23 polynomial tap constants
  - the symbol-scale shift constant
- Sub-module prbs_gen: parameterized Fibonacci LFSR with width, taps, seed, advance-enable and a 2-bit-per-cycle output. It is instantiated for PRBS15 and, under TX_NOISE_EN, for PRBS23.

## Test plan
- Reset: hold rst=0 for 3 cycles → o_sample=0, o_symbol=0, o_valid=0. Release with i_en=0 → outputs stay 0 for 10 cycles.
- Default run: i_en=1, i_ready=1, default seed/taps → o_valid rises on the 5th advance edge. The first 7 symbol codes are +1 and each corresponding sample = 8128.
- Taps h0=64, h1=32, others 0, default seed → in RUN while symbols are +1, o_sample=6144.
- Saturation: CH_LEN=8, all taps 127, PRBS_SEED=15'h5555 → first RUN sample has ≥7 symbols at +3 and o_sample=131071.
- Backpressure: drop i_ready for 3 cycles in RUN → o_sample/o_symbol are stable. After release, the sequence matches a no-stall reference model exactly.
- Mid-run reset / en drop:
  - rst=0 in RUN → next cycle outputs 0, state=IDLE, and the re-run reproduces the default-run sequence.
  - i_en=0 in RUN → o_valid=0 next cycle, and re-enabling repeats FILL.
